// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter: RAM handshake state and
// arbiter FSM encoding.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request ports and RAM-side ports of the arbiter, bundled so the
// arbiter (slave) and its environment (master) see complementary directions.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // instruction requester
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // data requester
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data memory.
// Data wins ties; a starvation counter forces an instruction grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             i_done;
  logic             d_done;

  assign d_req = bus.dREN || bus.dWEN;

  // State register; outputs decode from it so reset drops enables at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state   = state;
    i_done       = 1'b0;
    d_done       = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state)
      IDLE: begin
        if (bus.iREN && (!d_req || starve_cnt == LIMIT)) begin
          next_state = IGRANT;
        end else if (d_req) begin
          next_state = DGRANT;
        end
      end

      IGRANT: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          case (bus.ramstate)
            ACCESS: begin
              bus.iwait  = 1'b0;
              bus.iload  = bus.ramload;
              i_done     = 1'b1;
              next_state = IDLE;
            end
            ERROR:   next_state = IDLE;
            default: ;
          endcase
        end
      end

      DGRANT: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN && !bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          case (bus.ramstate)
            ACCESS: begin
              bus.dwait  = 1'b0;
              bus.dload  = bus.ramload;
              d_done     = 1'b1;
              next_state = IDLE;
            end
            ERROR:   next_state = IDLE;
            default: ;
          endcase
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // Consecutive data completions seen while an instruction fetch waits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (!bus.iREN || i_done) begin
      starve_cnt <= '0;
    end else if (d_done && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model: owner of the RAM, starvation run length and a word memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic CLK;
  logic nRST;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  // Model: who holds the RAM (0 none, 1 instruction, 2 data) and run length.
  int owner  = 0;
  int starve = 0;
  logic [31:0] mem [64];
  int i_seen = 0;
  int d_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // One clock: drive requests, play the RAM, compare, advance the model.
  // rs < 0 picks a random RAM response for a granted access.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input int rs,
                       output bit ic, output bit dc);
    bit          dreq;
    int          resp;
    int          nxt;
    int          r;
    logic [31:0] rl;
    logic        eren, ewen, eiw, edw;
    logic [31:0] eaddr, estore, eil, edl;

    dreq = dr || dw;
    ic = 0; dc = 0;
    bus.iREN = ir; bus.iaddr = ia;
    bus.dREN = dr; bus.dWEN = dw; bus.daddr = da; bus.dstore = ds;
    eren = 0; ewen = 0; eiw = 1; edw = 1;
    eaddr = 0; estore = 0; eil = 0; edl = 0;
    nxt = owner;
    if (rs < 0) begin
      r = $urandom_range(0, 9);
      resp = (r == 0) ? 3 : ((r < 4) ? 2 : 1);
    end else begin
      resp = rs;
    end
    rl = $urandom;

    if (owner == 1) begin
      if (!ir) nxt = 0;
      else begin
        eren = 1; eaddr = ia;
        if (resp == 2) begin
          rl = mem[idx(ia)]; eiw = 0; eil = rl; ic = 1; nxt = 0;
        end else if (resp == 3) nxt = 0;
      end
    end else if (owner == 2) begin
      if (!dreq) nxt = 0;
      else begin
        ewen = dw; eren = dr && !dw; eaddr = da; estore = ds;
        if (resp == 2) begin
          if (!dw) rl = mem[idx(da)];
          edw = 0; edl = rl; dc = 1; nxt = 0;
        end else if (resp == 3) nxt = 0;
      end
    end else begin
      nxt = (ir && (!dreq || starve == LIMIT)) ? 1 : (dreq ? 2 : 0);
    end

    if (eren || ewen) bus.ramstate = ramstate_t'(2'(resp));
    else bus.ramstate = ramstate_t'(2'($urandom_range(0, 3)));
    bus.ramload = rl;
    #2;
    chk("ramREN", 32'(bus.ramREN), 32'(eren));
    chk("ramWEN", 32'(bus.ramWEN), 32'(ewen));
    chk("ramaddr", bus.ramaddr, eaddr);
    chk("ramstore", bus.ramstore, estore);
    chk("iwait", 32'(bus.iwait), 32'(eiw));
    chk("dwait", 32'(bus.dwait), 32'(edw));
    chk("iload", bus.iload, eil);
    chk("dload", bus.dload, edl);
    if (bus.iwait === 1'b0) i_seen++;
    if (bus.dwait === 1'b0) d_seen++;

    if (dc && dw) mem[idx(da)] = ds;
    if (ic) starve = 0;
    if (dc && ir) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    if (!ir) starve = 0;
    owner = nxt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit ic, dc;
    int base, n;
    logic ir_c, dr_c, dw_c;
    logic [31:0] ia_c, da_c, ds_c;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    nRST = 1'b0;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hA5A5_A5A5; bus.ramstate = BUSY;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset values.
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_iwait", 32'(bus.iwait), 32'd1);
    chk("rst_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    nRST = 1'b1;
    owner = 0; starve = 0;

    // Instruction fetch with two BUSY cycles.
    base = i_seen;
    cycle(1, 32'h40, 0, 0, 0, 0, 1, ic, dc);
    cycle(1, 32'h40, 0, 0, 0, 0, 1, ic, dc);
    cycle(1, 32'h40, 0, 0, 0, 0, 1, ic, dc);
    cycle(1, 32'h40, 0, 0, 0, 0, 2, ic, dc);
    chk("t1_ipulse", 32'(i_seen - base), 32'd1);
    chk("t1_state", 32'(dut.state), 32'(IDLE));
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Simultaneous fetch and write: write first, fetch sees written word.
    base = i_seen;
    cycle(1, 32'h80, 0, 1, 32'h80, 32'hDEAD_BEEF, 2, ic, dc);
    cycle(1, 32'h80, 0, 1, 32'h80, 32'hDEAD_BEEF, 2, ic, dc);
    chk("t2_dfirst", 32'(dc), 32'd1);
    cycle(1, 32'h80, 0, 0, 0, 0, 2, ic, dc);
    cycle(1, 32'h80, 0, 0, 0, 0, 2, ic, dc);
    chk("t2_ithen", 32'(ic), 32'd1);
    chk("t2_iload", bus.iload, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Starvation: data held continuously, fetch forced after LIMIT grants.
    base = d_seen;
    n = 0;
    ic = 0;
    while (!ic && n < 30) begin
      cycle(1, 32'h10, 1, 0, 32'h20, 0, 2, ic, dc);
      n++;
    end
    chk("t3_igrant", 32'(ic), 32'd1);
    chk("t3_dcount", 32'(d_seen - base), 32'(LIMIT));
    chk("t3_starve", 32'(dut.starve_cnt), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Data read hits ERROR once, then retries.
    base = d_seen;
    cycle(0, 0, 1, 0, 32'h24, 0, 2, ic, dc);
    cycle(0, 0, 1, 0, 32'h24, 0, 3, ic, dc);
    cycle(0, 0, 1, 0, 32'h24, 0, 2, ic, dc);
    cycle(0, 0, 1, 0, 32'h24, 0, 2, ic, dc);
    chk("t4_dpulse", 32'(d_seen - base), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Reset in the middle of an instruction grant.
    cycle(1, 32'h48, 0, 0, 0, 0, 1, ic, dc);
    cycle(1, 32'h48, 0, 0, 0, 0, 1, ic, dc);
    bus.ramstate = ACCESS;
    #1;
    chk("t5_pre_ramREN", 32'(bus.ramREN), 32'd1);
    chk("t5_pre_iwait", 32'(bus.iwait), 32'd0);
    nRST = 1'b0;
    #1;
    chk("t5_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t5_iwait", 32'(bus.iwait), 32'd1);
    chk("t5_state", 32'(dut.state), 32'(IDLE));
    owner = 0; starve = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("t5_starve", 32'(dut.starve_cnt), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Read and write together: write wins.
    cycle(0, 0, 1, 1, 32'h30, 32'h0000_55AA, 2, ic, dc);
    cycle(0, 0, 1, 1, 32'h30, 32'h0000_55AA, 2, ic, dc);
    chk("t6_done", 32'(dc), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, -1, ic, dc);

    // Randomized traffic with held requests and occasional drops.
    ir_c = 0; dr_c = 0; dw_c = 0; ia_c = 0; da_c = 0; ds_c = 0;
    for (int k = 0; k < 600; k++) begin
      if (!ir_c) begin
        ir_c = ($urandom_range(0, 2) == 0);
        ia_c = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end else if ($urandom_range(0, 24) == 0) ir_c = 0;
      if (!(dr_c || dw_c)) begin
        if ($urandom_range(0, 2) == 0) begin
          dw_c = 1'($urandom_range(0, 1));
          dr_c = !dw_c || ($urandom_range(0, 3) == 0);
          da_c = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
          ds_c = $urandom;
        end
      end else if ($urandom_range(0, 24) == 0) begin
        dr_c = 0; dw_c = 0;
      end
      cycle(ir_c, ia_c, dr_c, dw_c, da_c, ds_c, -1, ic, dc);
      if (ic) begin
        ir_c = 1'($urandom_range(0, 1));
        ia_c = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (dc && $urandom_range(0, 1) == 0) begin
        dr_c = 0; dw_c = 0;
      end else if (dc) begin
        da_c = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        ds_c = $urandom;
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
